// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// fwd_hazard_unit : EX-stage operand forwarding selects, load-use stall
//                   detection and saturating stall-cycle counter.  rev 1.0
// ============================================================================
module fwd_hazard_unit #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [ADDR_W-1:0] id_rs_i,
  input  logic [ADDR_W-1:0] id_rt_i,
  input  logic [ADDR_W-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              flush_i,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic              stall_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam logic [1:0] SEL_REGFILE = 2'b00;
  localparam logic [1:0] SEL_EXMEM   = 2'b01;
  localparam logic [1:0] SEL_MEMWB   = 2'b10;

  // Shadow pipeline slots; MEM/WB keep only what forwarding needs.
  logic              ex_valid, ex_regwrite, ex_memread;
  logic [ADDR_W-1:0] ex_rs, ex_rt, ex_rd;
  logic              mem_valid, mem_regwrite;
  logic [ADDR_W-1:0] mem_rd;
  logic              wb_valid, wb_regwrite;
  logic [ADDR_W-1:0] wb_rd;
  logic [CNT_W-1:0]  stall_cnt;

  logic mem_writer, wb_writer, ex_load_writer, id_load_dep, ex_load;

  always_comb begin
    mem_writer     = mem_valid && mem_regwrite && (mem_rd != '0);
    wb_writer      = wb_valid  && wb_regwrite  && (wb_rd  != '0);
    ex_load_writer = ex_valid && ex_memread && ex_regwrite && (ex_rd != '0);
    id_load_dep    = (ex_rd == id_rs_i) || (ex_rd == id_rt_i);
    ex_load        = id_valid_i && !stall_o && !flush_i;
  end

  assign stall_o = ex_load_writer && id_valid_i && id_load_dep;

  // MEM has priority over WB: it holds the younger value of the register.
  always_comb begin
    fwd_a_o = SEL_REGFILE;
    fwd_b_o = SEL_REGFILE;
    if (ex_valid) begin
      if (mem_writer && (mem_rd == ex_rs))      fwd_a_o = SEL_EXMEM;
      else if (wb_writer && (wb_rd == ex_rs))   fwd_a_o = SEL_MEMWB;
      if (mem_writer && (mem_rd == ex_rt))      fwd_b_o = SEL_EXMEM;
      else if (wb_writer && (wb_rd == ex_rt))   fwd_b_o = SEL_MEMWB;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_valid     <= 1'b0;
      ex_rs        <= '0;
      ex_rt        <= '0;
      ex_rd        <= '0;
      ex_regwrite  <= 1'b0;
      ex_memread   <= 1'b0;
      mem_valid    <= 1'b0;
      mem_rd       <= '0;
      mem_regwrite <= 1'b0;
      wb_valid     <= 1'b0;
      wb_rd        <= '0;
      wb_regwrite  <= 1'b0;
    end else begin
      wb_valid     <= mem_valid;
      wb_rd        <= mem_rd;
      wb_regwrite  <= mem_regwrite;
      mem_valid    <= ex_valid;
      mem_rd       <= ex_rd;
      mem_regwrite <= ex_regwrite;
      ex_valid     <= ex_load;
      if (ex_load) begin
        ex_rs       <= id_rs_i;
        ex_rt       <= id_rt_i;
        ex_rd       <= id_rd_i;
        ex_regwrite <= id_regwrite_i;
        ex_memread  <= id_memread_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt <= '0;
    end else if (stall_o && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall_cnt_o = stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// tb_fwd_hazard_unit : scoreboard bench for fwd_hazard_unit.  rev 1.0
// ============================================================================
module tb_fwd_hazard_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, id_valid, id_regwrite, id_memread, flush;
  logic [4:0] id_rs, id_rt, id_rd;
  logic [1:0] fwd_a, fwd_b, fwd_a2, fwd_b2;
  logic       stall, stall2;
  logic [15:0] cnt;
  logic [1:0]  cnt2;

  fwd_hazard_unit #(.ADDR_W(5), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs_i(id_rs),
    .id_rt_i(id_rt), .id_rd_i(id_rd), .id_regwrite_i(id_regwrite),
    .id_memread_i(id_memread), .flush_i(flush), .fwd_a_o(fwd_a),
    .fwd_b_o(fwd_b), .stall_o(stall), .stall_cnt_o(cnt));

  fwd_hazard_unit #(.ADDR_W(5), .CNT_W(2)) dut_sat (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs_i(id_rs),
    .id_rt_i(id_rt), .id_rd_i(id_rd), .id_regwrite_i(id_regwrite),
    .id_memread_i(id_memread), .flush_i(flush), .fwd_a_o(fwd_a2),
    .fwd_b_o(fwd_b2), .stall_o(stall2), .stall_cnt_o(cnt2));

  // Reference model: instructions indexed by age (0=EX, 1=MEM, 2=WB).
  typedef struct {bit valid; int rs; int rt; int rd; bit rw; bit mr;} instr_t;
  typedef struct {logic [1:0] a; logic [1:0] b; logic st; int c16; int c2;} exp_t;

  instr_t pipe [3];
  exp_t   exp_q [$];
  exp_t   mon_e;
  int     checks = 0;
  int     failures = 0;
  int     m_cnt16 = 0;
  int     m_cnt2 = 0;
  bit     known = 0;

  function automatic logic [1:0] m_fwd(int src);
    if (!pipe[0].valid) return 2'b00;
    for (int age = 1; age <= 2; age++)
      if (pipe[age].valid && pipe[age].rw && pipe[age].rd != 0 && pipe[age].rd == src)
        return (age == 1) ? 2'b01 : 2'b10;
    return 2'b00;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk("fwd_a", 32'(fwd_a), 32'(mon_e.a));
      chk("fwd_b", 32'(fwd_b), 32'(mon_e.b));
      chk("stall", 32'(stall), 32'(mon_e.st));
      chk("stall_cnt", 32'(cnt), mon_e.c16);
      chk("sat_stall", 32'(stall2), 32'(mon_e.st));
      chk("sat_cnt", 32'(cnt2), mon_e.c2);
    end
  end

  task automatic step(bit r, bit v, int rs, int rt, int rd, bit rw, bit mr, bit fl,
                      output bit stalled);
    exp_t   e;
    instr_t ni;
    bit     st;
    rst = r; id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_rd = 5'(rd);
    id_regwrite = rw; id_memread = mr; flush = fl;
    st = pipe[0].valid && pipe[0].mr && pipe[0].rw && pipe[0].rd != 0 && v &&
         (pipe[0].rd == rs || pipe[0].rd == rt);
    if (known) begin
      e.a = m_fwd(pipe[0].rs); e.b = m_fwd(pipe[0].rt); e.st = st;
      e.c16 = m_cnt16; e.c2 = m_cnt2;
      exp_q.push_back(e);
    end
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 3; i++) pipe[i].valid = 0;
      m_cnt16 = 0; m_cnt2 = 0; known = 1;
    end else begin
      if (st) begin
        if (m_cnt16 < 65535) m_cnt16++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      ni.valid = v && !st && !fl; ni.rs = rs; ni.rt = rt; ni.rd = rd; ni.rw = rw; ni.mr = mr;
      pipe[2] = pipe[1]; pipe[1] = pipe[0]; pipe[0] = ni;
    end
    stalled = st && !r;
    #1;
  endtask

  // ID holds its instruction while stalled, as IF/ID would.
  task automatic issue(bit v, int rs, int rt, int rd, bit rw, bit mr, bit fl);
    bit s;
    step(0, v, rs, rt, rd, rw, mr, fl, s);
    for (int k = 0; k < 3 && s; k++) step(0, v, rs, rt, rd, rw, mr, fl, s);
  endtask

  task automatic nop(int n);
    for (int k = 0; k < n; k++) issue(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bit s;
    for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0, 0, 0};
    // reset with ID inputs toggling
    step(1, 1, 1, 2, 3, 1, 1, 0, s);
    step(1, 0, 3, 3, 4, 0, 1, 1, s);
    nop(2);
    // distance-1: add r3,r1,r2 ; sub r5,r3,r4
    issue(1, 1, 2, 3, 1, 0, 0); issue(1, 3, 4, 5, 1, 0, 0); nop(3);
    // distance-2: add r3 ; nop ; or r6,r7,r3  then the same with r0
    issue(1, 1, 2, 3, 1, 0, 0); nop(1); issue(1, 7, 3, 6, 1, 0, 0); nop(3);
    issue(1, 1, 2, 0, 1, 0, 0); nop(1); issue(1, 7, 0, 6, 1, 0, 0); nop(3);
    // double writer: add r3 ; addi r3 ; sub r8,r3,r3
    issue(1, 1, 2, 3, 1, 0, 0); issue(1, 1, 0, 3, 1, 0, 0); issue(1, 3, 3, 8, 1, 0, 0); nop(3);
    // load-use: lw r4,0(r1) ; add r9,r4,r2
    issue(1, 1, 0, 4, 1, 1, 0); issue(1, 4, 2, 9, 1, 0, 0); nop(3);
    // flushed writer then reader
    issue(1, 1, 2, 3, 1, 0, 1); issue(1, 3, 3, 10, 1, 0, 0); nop(3);
    // repeated load-use stalls to saturate the narrow counter
    for (int k = 0; k < 5; k++) begin
      issue(1, 1, 0, 4, 1, 1, 0); issue(1, 2, 4, 9, 1, 0, 0); nop(1);
    end
    nop(2);
    // randomized traffic over a small register set
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 49) == 0)
        step(1, $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), 1, 1, 0, s);
      else
        issue($urandom_range(0, 9) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 3,
              $urandom_range(0, 9) == 0);
    end
    nop(3);
    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
